down_timer: RTL

//   Loadable down-counting timer: the count-down companion to the team's 4-bit
//   up counter. Accepts a start value over a valid/ready load handshake and

---
 rtl/timer_pkg.sv | 13 +
 rtl/sat_counter.sv | 36 +++
 rtl/down_timer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: state encodings and default sizes.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH     = 4;
  localparam int unsigned TIMER_EXP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and an
// expiry tick, plus a saturating count of expiries since reset.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH     = TIMER_WIDTH,
  parameter int unsigned EXP_CNT_W = TIMER_EXP_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 load_auto,
  input  logic                 enable,
  input  logic                 abort,
  input  logic                 done_ack,
  output logic [WIDTH-1:0]     count_out,
  output logic                 busy,
  output logic                 done,
  output logic                 tick,
  output logic [EXP_CNT_W-1:0] expire_cnt
);

  timer_state_e     state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q,   auto_d;
  logic             tick_q,   tick_d;
  logic             accept;

  // Loads are taken only while idle or parked, and never alongside an abort.
  assign load_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !abort;
  assign accept     = load_valid && load_ready;

  // Next-state, count, reload/mode and tick; accepted load outranks ack/enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    auto_d   = auto_q;
    tick_d   = 1'b0;

    if (accept) begin
      count_d  = load_value;
      reload_d = load_value;
      auto_d   = load_auto;
      if (load_value == '0) begin
        // A zero start value expires immediately and never reloads.
        state_d = ST_DONE;
        tick_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else if (enable) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tick_d = 1'b1;
              if (auto_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (abort || done_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      tick_q   <= tick_d;
    end
  end

  // Expiry counter advances on the same edge the tick becomes visible.
  sat_counter #(
    .W (EXP_CNT_W)
  ) u_exp_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (tick_d),
    .clear (1'b0),
    .q     (expire_cnt)
  );

  assign count_out = count_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign tick      = tick_q;

endmodule : down_timer
